// File: rtl/spi_master_burst.sv
// rtl/spi_master_burst.sv - SPI master with SCK divider, CS framing and multi-word bursts
// Optional receive loopback from the MOSI register: SPI_MASTER_LOOPBACK_EN
module spi_master_burst #(
    parameter int   DATA_W = 8,
    parameter int   DIV_W  = 8,
    parameter logic CPOL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  half_div,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              spi_ss_n,
    output logic              spi_sck,
    output logic              spi_mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              spi_miso
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  h_q, h_d;
    logic              last_q, last_d;
    logic              sck_q, sck_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_bit;
    logic              accept;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = loopback ? mosi_q : spi_miso;
`else
    assign rx_bit = spi_miso;
`endif

    assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_NEXT && !last_q);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state_q != ST_IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign spi_ss_n = ss_n_q;
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        h_d        = h_q;
        last_d     = last_q;
        sck_d      = sck_q;
        ss_n_d     = ss_n_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        case (state_q)
            ST_IDLE, ST_NEXT: begin
                if (accept) begin
                    shift_d = tx_data;
                    last_d  = tx_last;
                    h_d     = half_div;
                    div_d   = half_div;
                    ss_n_d  = 1'b0;
                    mosi_d  = tx_data[DATA_W-1];
                    state_d = ST_SETUP;
                end else if (state_q == ST_NEXT && last_q) begin
                    div_d   = h_q;
                    state_d = ST_HOLD;
                end
            end
            ST_SETUP: begin
                if (div_q == '0) begin
                    div_d   = h_q;
                    cnt_d   = CNT_FULL;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = h_q;
                    if (cnt_q == '0) begin
                        // Mode 0 finishes on a falling edge; mode 3 is already idle-high
                        sck_d      = CPOL;
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                        state_d    = ST_NEXT;
                    end else begin
                        sck_d = ~sck_q;
                        if (!sck_q) begin
                            shift_d = {shift_q[DATA_W-2:0], rx_bit};
                            cnt_d   = cnt_q - 1'b1;
                        end else if (cnt_q != CNT_FULL) begin
                            // The mode 3 leading falling edge keeps the MSB on the line
                            mosi_d = shift_q[DATA_W-1];
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (div_q == '0) begin
                    ss_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            h_q        <= '0;
            last_q     <= 1'b0;
            sck_q      <= CPOL;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            h_q        <= h_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

endmodule
